// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment decode for the 7-segment scan driver.
// Segment order is {CA,CB,CC,CD,CE,CF,CG}, active low.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex_to_seg7(input logic [3:0] hex);
    return SEG7_HEX[hex];
  endfunction

endpackage

// File: rtl/seg7_lzb_mask.sv
// Leading-zero blanking mask: digit k>0 is blanked when enabled and every
// nibble from k up to the most significant digit is zero.
module seg7_lzb_mask #(
  parameter int N_DIGITS = 8
) (
  input  logic [4*N_DIGITS-1:0] snapshot,
  input  logic                  lzb_en,
  output logic [N_DIGITS-1:0]   blank
);

  logic zero_above;

  // NOTE: blocking assignments here are intentional; zero_above carries a
  // running AND from the top digit downwards within one evaluation, and every
  // variable gets a default first so no latch is inferred.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (snapshot[4*k +: 4] == 4'h0);
      blank[k]   = lzb_en & zero_above & (k != 0);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver with frame snapshots,
// per-digit enable, decimal points, leading-zero and anti-ghost blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  CLK100,
  input  logic                  resetn,
  input  logic [4*N_DIGITS-1:0] data_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   digit_en_i,
  input  logic                  lzb_en_i,
  input  logic                  freeze_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] snapshot;
  logic [N_DIGITS-1:0]   blank_mask;

  logic                  cnt_last;
  logic                  wrap;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_en;
  logic                  cur_blank;
  logic [N_DIGITS-1:0]   an_next;
  logic [6:0]            seg_next;

  seg7_lzb_mask #(.N_DIGITS(N_DIGITS)) u_lzb (
    .snapshot (snapshot),
    .lzb_en   (lzb_en_i),
    .blank    (blank_mask)
  );

  assign cnt_last = (cnt == CNT_LAST);
  assign wrap     = cnt_last && (idx == IDX_LAST);

  // Select the active digit with an explicit compare so a non-power-of-2
  // digit count never indexes past the end of the buses.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib   = snapshot[4*k +: 4];
        cur_dp    = dp_i[k];
        cur_en    = digit_en_i[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  always_comb begin
    an_next  = '1;
    seg_next = cur_blank ? SEG7_BLANK : hex_to_seg7(cur_nib);
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k) && ({1'b0, cnt} >= BLANK_END) && cur_en) begin
        an_next[k] = 1'b0;
      end
    end
  end

  // NOTE: all state, including the snapshot register, uses non-blocking
  // assignments and a synchronous active-low reset so every flop clears on
  // the same edge and scanning restarts cleanly from digit 0.
  always_ff @(posedge CLK100) begin
    if (!resetn) begin
      cnt      <= '0;
      idx      <= '0;
      snapshot <= '0;
      an_o     <= '1;
      seg_o    <= SEG7_BLANK;
      dp_o     <= 1'b1;
      frame_o  <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (wrap && !freeze_i) begin
        snapshot <= data_i;
      end
      frame_o <= wrap && !freeze_i;

      an_o  <= an_next;
      seg_o <= seg_next;
      dp_o  <= ~cur_dp;
    end
  end

endmodule
